apmu_ibex_pmu_counter_resp: RTL and testbench
=============================================

Name: apmu_ibex_pmu_counter_resp

Overview:
PMU-side responder for the core's counter interface (counter_op/gnt/rvalid/err/addr/we/wdata/rdata). It holds a bank of NumCounters 32-bit event counters, each with a period register and a sticky overflow flag. It serves single-cycle read/write requests (PMC_REQ) and blocking waits: PMC_WFP (wait for period) and PMC_WFO (wait for overflow). It sits in the APMU subsystem, directly facing the core's counter port.

Parameters:
NumCounters, 8, number of counters; power of two, 1..16
BaseAddr, 32'h0000_0000, byte base address of the register map; aligned to 8*NumCounters

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
counter_op_i  in  pmc_op_e  operation from the core (PMC_IDLE/PMC_REQ/PMC_WFP/PMC_WFO)
counter_gnt_o  out  1  ready to accept a new op
counter_rvalid_o  out  1  response valid, one-cycle pulse
counter_err_o  out  1  error qualifier, valid with rvalid
counter_addr_i  in  32  byte address
counter_we_i  in  1  write enable; meaningful for PMC_REQ only
counter_wdata_i  in  32  write data
counter_rdata_o  out  32  response data, valid with rvalid
event_i  in  NumCounters  per-counter increment strobes
overflow_o  out  NumCounters  sticky overflow flags

Behaviour:
- Clock and reset: one clock clk_i; reset is asynchronous, active-low (rst_ni).
- Reset values: counters, periods, overflow flags = 0; state IDLE; gnt=1, rvalid=0, err=0, rdata=0.
- Address decode: off = addr - BaseAddr. Valid iff off < 8*NumCounters and off[1:0]=0. Word w = off>>2. w<N selects counter[w]; N<=w<2N selects period[w-N].
- Counters: counter[k] += event_i[k] each cycle and wraps 0xFFFF_FFFF->0. A wrap sets overflow[k]. A bus write to counter[k] in the same cycle wins over the increment and clears overflow[k]. If a set and a clear of overflow[k] land in the same cycle, set wins.
- FSM states are IDLE, RESP and WAIT. gnt = (state==IDLE).
- IDLE: an op is accepted when gnt=1 and op!=PMC_IDLE.
  - PMC_REQ, valid address: perform the write (we=1) or capture the read. Go to RESP; rdata = target value (reads) or 0 (writes).
  - PMC_REQ, invalid address: go to RESP with err=1, rdata=0, no state change.
  - WFP/WFO with a counter address: latch index k and op, go to WAIT.
  - WFP/WFO with a period or invalid address: go to RESP with err=1, rdata=0.
- RESP: rvalid=1 for exactly one cycle, then return to IDLE. Latency from accept to rvalid is 1 cycle. A new op is accepted the cycle after rvalid.
- WAIT: the condition is evaluated every cycle on registered state.
  - WFP condition: counter[k] >= period[k], unsigned.
  - WFO condition: overflow[k]=1.
  - When the condition is met: capture rdata = counter[k] and go to RESP. WFO also clears overflow[k] on that transition.
  - Minimum latency from accept to rvalid is 2 cycles.
  - The core holds op stable during WAIT. If op drops to PMC_IDLE, abort to IDLE with no rvalid.
  - counter_we_i is ignored for WFP/WFO.
- Reset mid-operation: immediate return to reset values. Any pending wait is dropped with no response.
- No outstanding-request queue: at most one transaction in flight.

Decomposition:
- apmu_ibex_pkg: reuse pmc_op_e. Add pmc_resp_fsm_e {RESP_IDLE, RESP_RESP, RESP_WAIT} and a localparam helper for map size (8*NumCounters).
- Sub-module apmu_ibex_pmu_counter_bank: counters, periods, overflow flags, increment/wrap logic and single write port. Interface: idx, bank select, we, wdata, clear_ovf, plus read-out vectors.
- The responder top holds decode and the FSM.

Test Plan:
- Reset, then PMC_REQ write addr=BaseAddr+0x4 wdata=0x10 with event_i=0, then PMC_REQ read of the same address -> each rvalid 1 cycle after accept; read rdata=0x10, err=0, gnt low only in the RESP cycles.
- Write period[1]=5 (addr BaseAddr+4*(N+1)), counter[1]=0, PMC_WFP on addr BaseAddr+4, pulse event_i[1] on 5 cycles -> rvalid the cycle after counter[1] reaches 5, rdata=5.
- Write counter[2]=0xFFFF_FFFE, PMC_WFO on counter[2], two event_i[2] pulses -> overflow_o[2] rises on the wrap, rvalid with rdata=0, overflow_o[2] cleared after the response.
- PMC_REQ read at BaseAddr+8*N and at BaseAddr+0x2 -> rvalid with err=1, rdata=0; counters unchanged.
- Write to counter[0] coincident with event_i[0]=1 and current value 0xFFFF_FFFF -> counter[0]=wdata, overflow_o[0]=0.
- PMC_WFO pending, then assert rst_ni=0 mid-wait -> no rvalid; after release gnt=1 and all counters 0. Separately, op dropped to PMC_IDLE during WAIT -> returns to IDLE with no rvalid.

Source files
------------

// File: rtl/apmu_ibex_pkg.sv
// -----------------------------------------------------------------------------
// apmu_ibex_pkg
// Shared types and helpers for the APMU counter interface.
//   pmc_op_e        : operation encoding driven by the core on counter_op
//   pmc_resp_fsm_e  : state encoding of the PMU-side responder
//   pmc_map_bytes() : byte size of the register map (counters + periods)
//   pmc_idx_width() : width of a counter index, at least one bit
// -----------------------------------------------------------------------------
package apmu_ibex_pkg;

  typedef enum logic [1:0] {
    PMC_IDLE = 2'b00,
    PMC_REQ  = 2'b01,
    PMC_WFP  = 2'b10,
    PMC_WFO  = 2'b11
  } pmc_op_e;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'b00,
    RESP_RESP = 2'b01,
    RESP_WAIT = 2'b10
  } pmc_resp_fsm_e;

  // Each counter owns one 32-bit counter word and one 32-bit period word.
  function automatic int unsigned pmc_map_bytes(input int unsigned num_counters);
    return 8 * num_counters;
  endfunction

  function automatic int unsigned pmc_idx_width(input int unsigned num_counters);
    return (num_counters > 1) ? $clog2(num_counters) : 1;
  endfunction

endpackage

// File: rtl/apmu_ibex_pmu_counter_bank.sv
// -----------------------------------------------------------------------------
// apmu_ibex_pmu_counter_bank
// Bank of NumCounters 32-bit event counters, each with a period register and a
// sticky overflow flag. One write port shared by counters and periods.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   i_idx           : counter index for the write port and the overflow clear
//   i_sel_period    : write targets period[i_idx] instead of counter[i_idx]
//   i_we            : write strobe
//   i_wdata         : write data
//   i_clear_ovf     : clear overflow[i_idx]
//   i_event         : per-counter increment strobes
//   o_counters      : all counter values
//   o_periods       : all period values
//   o_overflow      : sticky overflow flags
// -----------------------------------------------------------------------------
module apmu_ibex_pmu_counter_bank
  import apmu_ibex_pkg::*;
#(
  parameter  int unsigned NumCounters = 8,
  localparam int unsigned IdxW        = pmc_idx_width(NumCounters)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [IdxW-1:0]                  i_idx,
  input  logic                             i_sel_period,
  input  logic                             i_we,
  input  logic [31:0]                      i_wdata,
  input  logic                             i_clear_ovf,
  input  logic [NumCounters-1:0]           i_event,
  output logic [NumCounters-1:0][31:0]     o_counters,
  output logic [NumCounters-1:0][31:0]     o_periods,
  output logic [NumCounters-1:0]           o_overflow
);

  for (genvar k = 0; k < NumCounters; k++) begin : g_ctr
    logic [31:0] r_cnt;
    logic [31:0] r_per;
    logic        r_ovf;
    logic        w_hit;
    logic        w_wr_cnt;
    logic        w_wr_per;
    logic        w_ovf_set;
    logic        w_ovf_clr;

    assign w_hit     = (i_idx == IdxW'(k));
    assign w_wr_cnt  = i_we && !i_sel_period && w_hit;
    assign w_wr_per  = i_we &&  i_sel_period && w_hit;
    // A bus write replaces the increment, so a write never produces a wrap.
    assign w_ovf_set = i_event[k] && (r_cnt == 32'hFFFF_FFFF) && !w_wr_cnt;
    assign w_ovf_clr = w_wr_cnt || (i_clear_ovf && w_hit);

    // NOTE: counters and periods are architecturally visible and must read 0
    // after reset, so this bank is built from resettable flops, not a RAM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt <= '0;
        r_per <= '0;
        r_ovf <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments keep every flop sampling the
        // pre-edge values, so the wrap test above sees the old count.
        if (w_wr_cnt) begin
          r_cnt <= i_wdata;
        end else if (i_event[k]) begin
          r_cnt <= r_cnt + 32'd1;
        end

        if (w_wr_per) begin
          r_per <= i_wdata;
        end

        // Set has priority so a wrap is never lost to a concurrent clear.
        if (w_ovf_set) begin
          r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
          r_ovf <= 1'b0;
        end
      end
    end

    assign o_counters[k] = r_cnt;
    assign o_periods[k]  = r_per;
    assign o_overflow[k] = r_ovf;
  end

endmodule

// File: rtl/apmu_ibex_pmu_counter_resp.sv
// -----------------------------------------------------------------------------
// apmu_ibex_pmu_counter_resp
// PMU-side responder for the core's counter port. Decodes the byte address
// into counter / period words, serves single-cycle reads and writes, and
// implements the blocking wait-for-period and wait-for-overflow operations.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   counter_op_i       : operation from the core
//   counter_gnt_o      : high while idle and able to accept an op
//   counter_rvalid_o   : one-cycle response strobe
//   counter_err_o      : error qualifier, valid with rvalid
//   counter_addr_i     : byte address
//   counter_we_i       : write enable (PMC_REQ only)
//   counter_wdata_i    : write data
//   counter_rdata_o    : response data, valid with rvalid
//   event_i            : per-counter increment strobes
//   overflow_o         : sticky overflow flags
// Map: word w of (addr - BaseAddr): w < N is counter[w], N <= w < 2N is
// period[w-N]; anything else or a misaligned address is an error.
// -----------------------------------------------------------------------------
module apmu_ibex_pmu_counter_resp
  import apmu_ibex_pkg::*;
#(
  parameter int unsigned NumCounters = 8,
  parameter logic [31:0] BaseAddr    = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  pmc_op_e                counter_op_i,
  output logic                   counter_gnt_o,
  output logic                   counter_rvalid_o,
  output logic                   counter_err_o,
  input  logic [31:0]            counter_addr_i,
  input  logic                   counter_we_i,
  input  logic [31:0]            counter_wdata_i,
  output logic [31:0]            counter_rdata_o,
  input  logic [NumCounters-1:0] event_i,
  output logic [NumCounters-1:0] overflow_o
);

  localparam int unsigned IdxW      = pmc_idx_width(NumCounters);
  localparam logic [31:0] MapBytes  = 32'(pmc_map_bytes(NumCounters));
  localparam logic [31:0] PeriodOff = 32'(4 * NumCounters);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]     w_off;
  logic            w_addr_ok;
  logic            w_is_period;
  logic [IdxW-1:0] w_dec_idx;

  // Subtraction wraps for addresses below BaseAddr, which then fail the
  // range check like any other out-of-map address.
  assign w_off       = counter_addr_i - BaseAddr;
  assign w_addr_ok   = (w_off < MapBytes) && (w_off[1:0] == 2'b00);
  assign w_is_period = (w_off >= PeriodOff);
  // With a power-of-two bank the low word bits are the index for both halves.
  assign w_dec_idx   = (NumCounters > 1) ? w_off[2 +: IdxW] : '0;

  // ---------------------------------------------------------------------------
  // Counter bank
  // ---------------------------------------------------------------------------
  logic [NumCounters-1:0][31:0] w_cnt;
  logic [NumCounters-1:0][31:0] w_per;
  logic [NumCounters-1:0]       w_ovf;
  logic [IdxW-1:0]              w_bank_idx;
  logic                         w_bank_sel;
  logic                         w_bank_we;
  logic                         w_clear_ovf;

  apmu_ibex_pmu_counter_bank #(
    .NumCounters (NumCounters)
  ) u_bank (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .i_idx        (w_bank_idx),
    .i_sel_period (w_bank_sel),
    .i_we         (w_bank_we),
    .i_wdata      (counter_wdata_i),
    .i_clear_ovf  (w_clear_ovf),
    .i_event      (event_i),
    .o_counters   (w_cnt),
    .o_periods    (w_per),
    .o_overflow   (w_ovf)
  );

  // ---------------------------------------------------------------------------
  // Responder FSM
  // ---------------------------------------------------------------------------
  pmc_resp_fsm_e   r_state;
  pmc_resp_fsm_e   w_state_nxt;
  logic [IdxW-1:0] r_k;
  logic [IdxW-1:0] w_k_nxt;
  logic            r_wfo;
  logic            w_wfo_nxt;
  logic [31:0]     r_rdata;
  logic [31:0]     w_rdata_nxt;
  logic            r_err;
  logic            w_err_nxt;
  logic            w_cond;

  // Wait condition uses registered bank state only, never this cycle's events.
  assign w_cond = r_wfo ? w_ovf[r_k] : (w_cnt[r_k] >= w_per[r_k]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= RESP_IDLE;
      r_k     <= '0;
      r_wfo   <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_wfo   <= w_wfo_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a variable unassigned and infers a latch.
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_wfo_nxt   = r_wfo;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    w_bank_idx  = w_dec_idx;
    w_bank_sel  = w_is_period;
    w_bank_we   = 1'b0;
    w_clear_ovf = 1'b0;

    case (r_state)
      RESP_IDLE: begin
        if (counter_op_i != PMC_IDLE) begin
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b0;
          case (counter_op_i)
            PMC_REQ: begin
              w_state_nxt = RESP_RESP;
              if (!w_addr_ok) begin
                w_err_nxt = 1'b1;
              end else if (counter_we_i) begin
                w_bank_we = 1'b1;
              end else begin
                w_rdata_nxt = w_is_period ? w_per[w_dec_idx] : w_cnt[w_dec_idx];
              end
            end
            PMC_WFP, PMC_WFO: begin
              // Waits are only defined on counter words.
              if (w_addr_ok && !w_is_period) begin
                w_state_nxt = RESP_WAIT;
                w_k_nxt     = w_dec_idx;
                w_wfo_nxt   = (counter_op_i == PMC_WFO);
              end else begin
                w_state_nxt = RESP_RESP;
                w_err_nxt   = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      RESP_RESP: begin
        // Drop the response payload so rdata/err read 0 between responses.
        w_state_nxt = RESP_IDLE;
        w_rdata_nxt = '0;
        w_err_nxt   = 1'b0;
      end

      RESP_WAIT: begin
        w_bank_idx = r_k;
        if (counter_op_i == PMC_IDLE) begin
          // Core withdrew the wait: no response is owed.
          w_state_nxt = RESP_IDLE;
        end else if (w_cond) begin
          w_state_nxt = RESP_RESP;
          w_rdata_nxt = w_cnt[r_k];
          w_err_nxt   = 1'b0;
          w_clear_ovf = r_wfo;
        end
      end

      default: begin
        w_state_nxt = RESP_IDLE;
      end
    endcase
  end

  assign counter_gnt_o    = (r_state == RESP_IDLE);
  assign counter_rvalid_o = (r_state == RESP_RESP);
  assign counter_err_o    = r_err;
  assign counter_rdata_o  = r_rdata;
  assign overflow_o       = w_ovf;

endmodule

// File: tb/tb_apmu_ibex_pmu_counter_resp.sv
// -----------------------------------------------------------------------------
// tb_apmu_ibex_pmu_counter_resp
// Directed bench for the PMU counter responder with N=8 and a non-zero base.
// -----------------------------------------------------------------------------
module tb_apmu_ibex_pmu_counter_resp;
  import apmu_ibex_pkg::*;

  localparam int unsigned N = 8;
  localparam logic [31:0] B = 32'h4000_0100;

  logic          clk = 1'b0;
  logic          rst_n;
  pmc_op_e       op;
  logic          gnt;
  logic          rvalid;
  logic          err;
  logic [31:0]   addr;
  logic          we;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [N-1:0]  ev;
  logic [N-1:0]  ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  apmu_ibex_pmu_counter_resp #(
    .NumCounters (N),
    .BaseAddr    (B)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .counter_op_i     (op),
    .counter_gnt_o    (gnt),
    .counter_rvalid_o (rvalid),
    .counter_err_o    (err),
    .counter_addr_i   (addr),
    .counter_we_i     (we),
    .counter_wdata_i  (wdata),
    .counter_rdata_o  (rdata),
    .event_i          (ev),
    .overflow_o       (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op, holds it until rvalid (bounded), then drops to idle and
  // lets the responder return to IDLE. lat=0 means no response arrived.
  task automatic do_req(input pmc_op_e o, input logic [31:0] a, input logic w,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic er, output int lat, output logic g);
    op = o; addr = a; we = w; wdata = d;
    lat = 0; rd = 'x; er = 1'bx; g = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rvalid === 1'b1) begin
        lat = i; rd = rdata; er = err; g = gnt;
        break;
      end
    end
    op = PMC_IDLE; we = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    op = PMC_IDLE; addr = '0; we = 1'b0; wdata = '0; ev = '0;
    rst_n = 1'b0;
    tick(); tick();
    n_checks++;
    if ({gnt, rvalid, err, rdata, ovf} !== {1'b1, 1'b0, 1'b0, 32'h0, 8'h0}) begin
      n_fail++;
      $display("FAIL reset_values: gnt=%b rvalid=%b err=%b rdata=%h ovf=%h, want 1 0 0 0 0",
               gnt, rvalid, err, rdata, ovf);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({gnt, rvalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: gnt=%b rvalid=%b, want 1 0", gnt, rvalid);
    end
  endtask

  task automatic test_rw();
    logic [31:0] rd; logic er; int lat; logic g;
    do_req(PMC_REQ, B + 32'h4, 1'b1, 32'h10, rd, er, lat, g);
    n_checks++;
    if (lat != 1 || er !== 1'b0 || rd !== 32'h0 || g !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_write: lat=%0d err=%b rdata=%h gnt=%b, want 1 0 0 0", lat, er, rd, g);
    end
    n_checks++;
    if (gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rw_gnt_back: gnt=%b want 1", gnt);
    end
    do_req(PMC_REQ, B + 32'h4, 1'b0, 32'h0, rd, er, lat, g);
    n_checks++;
    if (lat != 1 || er !== 1'b0 || rd !== 32'h10 || g !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_read: lat=%0d err=%b rdata=%h gnt=%b, want 1 0 00000010 0", lat, er, rd, g);
    end
    do_req(PMC_REQ, B + 4 * (N + 3), 1'b1, 32'hCAFE_0003, rd, er, lat, g);
    do_req(PMC_REQ, B + 4 * (N + 3), 1'b0, 32'h0, rd, er, lat, g);
    n_checks++;
    if (rd !== 32'hCAFE_0003 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_period3: rdata=%h err=%b, want cafe0003 0", rd, er);
    end
    do_req(PMC_REQ, B + 32'hC, 1'b0, 32'h0, rd, er, lat, g);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL rw_counter3_untouched: rdata=%h want 0", rd);
    end
  endtask

  task automatic test_wfp();
    logic [31:0] rd; logic er; int lat; logic g; logic early;
    do_req(PMC_REQ, B + 4 * (N + 1), 1'b1, 32'd5, rd, er, lat, g);
    do_req(PMC_REQ, B + 32'h4, 1'b1, 32'd0, rd, er, lat, g);
    // we/wdata set to junk: they must be ignored by a wait.
    op = PMC_WFP; addr = B + 32'h4; we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    early = rvalid | gnt;
    for (int i = 0; i < 5; i++) begin
      ev[1] = 1'b1;
      tick();
      ev = '0;
      early |= rvalid;
      if (i < 4) begin
        tick();
        early |= rvalid;
      end
    end
    n_checks++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL wfp_early: early response/gnt seen=%b want 0", early);
    end
    tick();
    n_checks++;
    if ({rvalid, err, rdata} !== {1'b1, 1'b0, 32'd5}) begin
      n_fail++;
      $display("FAIL wfp_resp: rvalid=%b err=%b rdata=%h, want 1 0 00000005", rvalid, err, rdata);
    end
    op = PMC_IDLE; we = 1'b0;
    tick();
    n_checks++;
    if ({gnt, rvalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL wfp_idle: gnt=%b rvalid=%b, want 1 0", gnt, rvalid);
    end
    // Condition already true: minimum latency of two cycles.
    do_req(PMC_WFP, B + 32'h4, 1'b0, 32'h0, rd, er, lat, g);
    n_checks++;
    if (lat != 2 || rd !== 32'd5 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL wfp_min_latency: lat=%0d rdata=%h err=%b, want 2 00000005 0", lat, rd, er);
    end
  endtask

  task automatic test_wfo();
    logic [31:0] rd; logic er; int lat; logic g; logic early;
    do_req(PMC_REQ, B + 32'h8, 1'b1, 32'hFFFF_FFFE, rd, er, lat, g);
    op = PMC_WFO; addr = B + 32'h8;
    tick();
    early = rvalid | ovf[2];
    ev[2] = 1'b1;
    tick();
    ev = '0;
    early |= rvalid | ovf[2];
    ev[2] = 1'b1;
    tick();
    ev = '0;
    n_checks++;
    if ({early, ovf[2], rvalid} !== 3'b010) begin
      n_fail++;
      $display("FAIL wfo_ovf_rise: early=%b ovf2=%b rvalid=%b, want 0 1 0", early, ovf[2], rvalid);
    end
    tick();
    n_checks++;
    if ({rvalid, err, rdata, ovf[2]} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL wfo_resp: rvalid=%b err=%b rdata=%h ovf2=%b, want 1 0 0 0",
               rvalid, err, rdata, ovf[2]);
    end
    op = PMC_IDLE;
    tick();
    n_checks++;
    if ({gnt, ovf} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL wfo_after: gnt=%b ovf=%h, want 1 00", gnt, ovf);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; logic g;
    pmc_op_e     e_op   [6];
    logic [31:0] e_addr [6];
    logic        e_we   [6];
    e_op   = '{PMC_REQ, PMC_REQ, PMC_REQ, PMC_REQ, PMC_WFO, PMC_WFP};
    e_addr = '{B + 8 * N, B + 32'h2, B - 32'h4, B + 32'h1, B + 4 * N, B + 8 * N + 4};
    e_we   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_req(e_op[i], e_addr[i], e_we[i], 32'h77, rd, er, lat, g);
      n_checks++;
      if (lat != 1 || er !== 1'b1 || rd !== 32'h0) begin
        n_fail++;
        $display("FAIL err_vec%0d: addr=%h lat=%0d err=%b rdata=%h, want 1 1 0",
                 i, e_addr[i], lat, er, rd);
      end
    end
    do_req(PMC_REQ, B, 1'b0, 32'h0, rd, er, lat, g);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL err_counter0_untouched: rdata=%h want 0", rd);
    end
    do_req(PMC_REQ, B + 32'h4, 1'b0, 32'h0, rd, er, lat, g);
    n_checks++;
    if (rd !== 32'd5) begin
      n_fail++;
      $display("FAIL err_counter1_untouched: rdata=%h want 5", rd);
    end
  endtask

  task automatic test_write_wins();
    logic [31:0] rd; logic er; int lat; logic g;
    do_req(PMC_REQ, B, 1'b1, 32'hFFFF_FFFF, rd, er, lat, g);
    op = PMC_REQ; addr = B; we = 1'b1; wdata = 32'h1234_5678; ev[0] = 1'b1;
    tick();
    ev = '0; op = PMC_IDLE; we = 1'b0;
    n_checks++;
    if ({rvalid, ovf[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL wins_collide: rvalid=%b ovf0=%b, want 1 0", rvalid, ovf[0]);
    end
    tick();
    do_req(PMC_REQ, B, 1'b0, 32'h0, rd, er, lat, g);
    n_checks++;
    if (rd !== 32'h1234_5678 || ovf[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL wins_value: rdata=%h ovf0=%b, want 12345678 0", rd, ovf[0]);
    end
    // A plain wrap sets the flag; a later counter write clears it.
    do_req(PMC_REQ, B + 32'hC, 1'b1, 32'hFFFF_FFFF, rd, er, lat, g);
    ev[3] = 1'b1;
    tick();
    ev = '0;
    n_checks++;
    if (ovf !== 8'h08) begin
      n_fail++;
      $display("FAIL wrap_sets_ovf: ovf=%h want 08", ovf);
    end
    do_req(PMC_REQ, B + 32'hC, 1'b1, 32'd7, rd, er, lat, g);
    n_checks++;
    if (ovf !== 8'h00) begin
      n_fail++;
      $display("FAIL write_clears_ovf: ovf=%h want 00", ovf);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int lat; logic g; logic bad;
    op = PMC_WFO; addr = B + 32'h10;
    tick();
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bad |= rvalid | gnt;
      tick();
    end
    op = PMC_IDLE;
    tick();
    n_checks++;
    if ({bad, gnt, rvalid} !== 3'b010) begin
      n_fail++;
      $display("FAIL abort_idle: wait_bad=%b gnt=%b rvalid=%b, want 0 1 0", bad, gnt, rvalid);
    end
    tick();
    n_checks++;
    if (rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_resp: rvalid=%b want 0", rvalid);
    end
    do_req(PMC_REQ, B + 32'h4, 1'b0, 32'h0, rd, er, lat, g);
    n_checks++;
    if (lat != 1 || rd !== 32'd5) begin
      n_fail++;
      $display("FAIL abort_then_read: lat=%0d rdata=%h, want 1 00000005", lat, rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; logic g;
    logic [31:0] r_addr [3];
    op = PMC_WFO; addr = B + 32'h14;
    tick(); tick();
    n_checks++;
    if (gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_waiting: gnt=%b want 0", gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt, rvalid, rdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL rstmid_async: gnt=%b rvalid=%b rdata=%h, want 1 0 0", gnt, rvalid, rdata);
    end
    op = PMC_IDLE;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({gnt, rvalid, ovf} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL rstmid_release: gnt=%b rvalid=%b ovf=%h, want 1 0 00", gnt, rvalid, ovf);
    end
    r_addr = '{B, B + 32'h4, B + 4 * (N + 3)};
    for (int i = 0; i < 3; i++) begin
      do_req(PMC_REQ, r_addr[i], 1'b0, 32'h0, rd, er, lat, g);
      n_checks++;
      if (rd !== 32'h0 || er !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_cleared%0d: addr=%h rdata=%h err=%b, want 0 0", i, r_addr[i], rd, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_wfp();
    test_wfo();
    test_errors();
    test_write_wins();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
